// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-flight write scoreboard, forwarding selects, stall/bubble and DMA bus hold
module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int REG_AW     = 5,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_writes,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              dma_hold_req,
  output logic              stall,
  output logic              bubble,
  output logic [SEL_W-1:0]  fwd_sel_rs,
  output logic [SEL_W-1:0]  fwd_sel_rt,
  output logic              dma_hold_ack
);

  typedef enum logic [1:0] {RUN, DRAIN, GRANT} bus_state_t;

  bus_state_t state, state_next;

  // Position k holds the write that left ID k cycles ago (1=EX, 2=MEM, 3=WB).
  logic              sb_valid [1:STAGES];
  logic [REG_AW-1:0] sb_dest  [1:STAGES];
  logic              sb_load  [1:STAGES];

  logic             rs_hit, rs_rdy, rt_hit, rt_rdy;
  logic [SEL_W-1:0] rs_pos, rt_pos;
  logic             any_valid;
  logic             data_stall;
  logic             bus_hold;
  logic             insert;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    rs_hit    = 1'b0;
    rs_rdy    = 1'b0;
    rs_pos    = '0;
    rt_hit    = 1'b0;
    rt_rdy    = 1'b0;
    rt_pos    = '0;
    any_valid = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      any_valid = any_valid | sb_valid[k];
      if (id_use_rs && (id_rs != '0) && sb_valid[k] && (sb_dest[k] == id_rs)) begin
        rs_hit = 1'b1;
        rs_pos = SEL_W'(k);
        rs_rdy = (k >= (sb_load[k] ? LOAD_READY : ALU_READY));
      end
      if (id_use_rt && (id_rt != '0) && sb_valid[k] && (sb_dest[k] == id_rt)) begin
        rt_hit = 1'b1;
        rt_pos = SEL_W'(k);
        rt_rdy = (k >= (sb_load[k] ? LOAD_READY : ALU_READY));
      end
    end
  end

  always_comb begin
    bus_hold   = (state != RUN);
    data_stall = id_valid & ~flush & ((rs_hit & ~rs_rdy) | (rt_hit & ~rt_rdy));
    stall      = bus_hold | data_stall;
    bubble     = bus_hold | data_stall | flush;
    fwd_sel_rs = (rs_hit && rs_rdy) ? rs_pos : '0;
    fwd_sel_rt = (rt_hit && rt_rdy) ? rt_pos : '0;
    insert     = id_valid & id_writes & ~flush & ~stall & ~bubble;
  end

  // A dropped request during DRAIN wins over an empty pipeline.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dma_hold_req) state_next = DRAIN;
      DRAIN: begin
        if (!dma_hold_req)   state_next = RUN;
        else if (!any_valid) state_next = GRANT;
      end
      GRANT:   if (!dma_hold_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      dma_hold_ack <= 1'b0;
    end else begin
      state        <= state_next;
      dma_hold_ack <= (state_next == GRANT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_valid[k] <= 1'b0;
        sb_dest[k]  <= '0;
        sb_load[k]  <= 1'b0;
      end
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dest[k]  <= sb_dest[k-1];
        sb_load[k]  <= sb_load[k-1];
      end
      sb_valid[1] <= insert;
      sb_dest[1]  <= id_dest;
      sb_load[1]  <= id_is_load;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_use_rs = 1'b0;
  logic       id_use_rt = 1'b0;
  logic       id_writes = 1'b0;
  logic [4:0] id_dest = '0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;
  logic       dma_hold_req = 1'b0;
  logic       stall, bubble, dma_hold_ack;
  logic [1:0] fwd_sel_rs, fwd_sel_rt;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_writes(id_writes),
    .id_dest(id_dest), .id_is_load(id_is_load), .flush(flush),
    .dma_hold_req(dma_hold_req), .stall(stall), .bubble(bubble),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .dma_hold_ack(dma_hold_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] e(input logic st, input logic bb, input logic [1:0] srs,
                                   input logic [1:0] srt, input logic ak);
    return {st, bb, srs, srt, ak};
  endfunction

  // Drive one ID cycle just after the edge and queue what the outputs must be in that cycle.
  task automatic cyc(input string nm, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic wr, input logic [4:0] dest,
                     input logic ld, input logic fl, input logic req, input logic rst,
                     input logic [6:0] expv);
    @(posedge clk);
    #1;
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_writes = wr; id_dest = dest; id_is_load = ld; flush = fl; dma_hold_req = req;
    rst_n = ~rst;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [6:0] act, expv;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        act  = {stall, bubble, fwd_sel_rs, fwd_sel_rt, dma_hold_ack};
        checks++;
        if (act !== expv) begin
          errors++;
          $display("FAIL %s: got stall=%b bubble=%b rs=%0d rt=%0d ack=%b, want stall=%b bubble=%b rs=%0d rt=%0d ack=%b",
                   nm, act[6], act[5], act[4:3], act[2:1], act[0],
                   expv[6], expv[5], expv[4:3], expv[2:1], expv[0]);
        end
      end
    end
  end

  initial begin : stim
    //            name         v  rs  rt urs urt wr dst ld fl req rst expected
    cyc("rst_state",    1, 3,  5, 1, 1, 1, 3,  1, 0, 1, 1, e(0,0,0,0,0));
    cyc("alu_issue",    1, 1,  2, 1, 1, 1, 3,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("alu_ex",       1, 3,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,1,0,0));
    cyc("alu_mem",      1, 3,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,2,0,0));
    cyc("alu_wb",       1, 3,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,3,0,0));
    cyc("alu_retired",  1, 3,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("lw_issue",     1, 0,  0, 0, 0, 1, 5,  1, 0, 0, 0, e(0,0,0,0,0));
    cyc("lu_stall",     1, 0,  5, 0, 1, 1, 6,  0, 0, 0, 0, e(1,1,0,0,0));
    cyc("lu_fwd",       1, 0,  5, 0, 1, 1, 6,  0, 0, 0, 0, e(0,0,0,2,0));
    repeat (3) cyc("idle_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0));
    cyc("y_old4",       1, 0,  0, 0, 0, 1, 4,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("y_nowrite",    1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("y_new4",       1, 0,  0, 0, 0, 1, 4,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("youngest",     1, 4,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,1,0,0));
    cyc("lw_r0",        1, 0,  0, 0, 0, 1, 0,  1, 0, 0, 0, e(0,0,0,0,0));
    cyc("r0_no_match",  1, 0,  0, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,0,0,0));
    repeat (3) cyc("idle_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0));
    cyc("fl_lw",        1, 0,  0, 0, 0, 1, 7,  1, 0, 0, 0, e(0,0,0,0,0));
    cyc("flush_stall",  1, 7,  0, 1, 0, 1, 8,  0, 1, 0, 0, e(0,1,0,0,0));
    cyc("flush_noins",  1, 8,  7, 1, 1, 0, 0,  0, 0, 0, 0, e(0,0,0,2,0));
    repeat (2) cyc("idle_c", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0));
    cyc("dma_fill1",    1, 0,  0, 0, 0, 1, 9,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("dma_fill2",    1, 0,  0, 0, 0, 1, 10, 0, 0, 0, 0, e(0,0,0,0,0));
    cyc("dma_fill3",    1, 0,  0, 0, 0, 1, 11, 0, 0, 0, 0, e(0,0,0,0,0));
    cyc("dma_req",      0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(0,0,0,0,0));
    cyc("drain1",       1, 0,  0, 0, 0, 1, 12, 0, 0, 1, 0, e(1,1,0,0,0));
    cyc("drain2_fwd",   1, 11, 0, 1, 0, 0, 0,  0, 0, 1, 0, e(1,1,3,0,0));
    cyc("drain3",       0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(1,1,0,0,0));
    cyc("grant1",       0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(1,1,0,0,1));
    cyc("grant_drop",   0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, e(1,1,0,0,1));
    cyc("run_after",    0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, e(0,0,0,0,0));
    cyc("r_req",        0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(0,0,0,0,0));
    cyc("r_drain",      0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(1,1,0,0,0));
    cyc("r_grant",      0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(1,1,0,0,1));
    cyc("rst_in_grant", 1, 3,  0, 1, 0, 0, 0,  0, 0, 1, 1, e(0,0,0,0,0));
    cyc("post_rst_run", 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0, e(0,0,0,0,0));
    cyc("drain_abort",  0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, e(1,1,0,0,0));
    cyc("abort_run",    0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, e(0,0,0,0,0));

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
